// File: rtl/seg7_shift_ctrl.sv
// rtl/seg7_shift_ctrl.sv - serialiser from a 64-bit segment image to chained 74HC595 shift registers
//
// Purpose: bit-bangs a 64-bit segment image MSB first over sclk/sdat, then pulses
// sload so the chain latches it. Frames start on a periodic refresh tick or on an
// update pulse. Also produces the blink square wave fed back to the formatter.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous reset, active low
//   i_en       allows refresh ticks and update pulses to start frames
//   i_update   one-cycle request for an immediate frame
//   i_seg_in   segment image, captured only in LOAD
//   o_sclk     shift clock (chain samples on its rising edge)
//   o_sdat     serial data, changes only while sclk is low
//   o_sload    latch strobe, high for DIV cycles after bit 0
//   o_busy     high from LOAD through the last LATCH cycle
//   o_done     one-cycle pulse, first IDLE cycle after a frame
//   o_flash    blink square wave, toggles every FLASH_FRAMES frames
module seg7_shift_ctrl #(
    parameter int DIV          = 2,
    parameter int REFRESH      = 50000,
    parameter int FLASH_FRAMES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_update,
    input  logic [63:0] i_seg_in,
    output logic        o_sclk,
    output logic        o_sdat,
    output logic        o_sload,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_flash
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [63:0]   r_shadow;
    logic [5:0]    r_bitcnt;
    logic [DW-1:0] r_div;
    logic [RW-1:0] r_ref;
    logic [FW-1:0] r_frames;
    logic          r_pend;
    logic          r_sclk;
    logic          r_sdat;
    logic          r_sload;
    logic          r_busy;
    logic          r_done;
    logic          r_flash;

    logic w_tick;
    logic w_trig;
    logic w_start;
    logic w_half_end;
    logic w_last_bit;
    logic w_fall;
    logic w_sclk_nx;
    logic w_sdat_nx;
    logic w_sload_nx;
    logic w_busy_nx;
    logic w_done_nx;
    logic w_flash_nx;

    assign w_tick     = (r_ref == REF_LAST);
    assign w_trig     = (w_tick | i_update) & i_en;
    assign w_start    = (r_state == S_IDLE) & r_pend;
    assign w_half_end = (r_div == DIV_LAST);
    assign w_last_bit = (r_bitcnt == 6'd0);
    // End of a high phase that is not the final bit: sclk falls and the next bit is presented.
    assign w_fall     = (r_state == S_SHIFT) & w_half_end & r_sclk & ~w_last_bit;

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_sclk  <= 1'b0;
            r_sdat  <= 1'b0;
            r_sload <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_flash <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sclk  <= w_sclk_nx;
            r_sdat  <= w_sdat_nx;
            r_sload <= w_sload_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_flash <= w_flash_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_pend) w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: if (w_half_end && r_sclk && w_last_bit) w_next = S_LATCH;
            S_LATCH: if (w_half_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        w_sclk_nx  = 1'b0;
        w_sdat_nx  = r_sdat;
        if (r_state == S_SHIFT) begin
            w_sclk_nx = w_half_end ? ~r_sclk : r_sclk;
        end
        if (r_state == S_LOAD) begin
            w_sdat_nx = i_seg_in[63];
        end else if (w_fall) begin
            w_sdat_nx = r_shadow[62];
        end
        w_sload_nx = (w_next == S_LATCH);
        w_busy_nx  = (w_next != S_IDLE);
        w_done_nx  = (r_state == S_LATCH) && (w_next == S_IDLE);
        w_flash_nx = (w_done_nx && (r_frames == FRM_LAST)) ? ~r_flash : r_flash;
    end

    // Datapath: shadow image, bit counter, sclk divider, refresh timer, frame counter, pending
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
            r_bitcnt <= '0;
            r_div    <= '0;
            r_ref    <= '0;
            r_frames <= '0;
            r_pend   <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_shadow <= i_seg_in;
                r_bitcnt <= 6'd63;
            end else if (w_fall) begin
                r_shadow <= {r_shadow[62:0], 1'b0};
                r_bitcnt <= r_bitcnt - 6'd1;
            end

            if (((r_state == S_SHIFT) || (r_state == S_LATCH)) && !w_half_end) begin
                r_div <= r_div + DW'(1);
            end else begin
                r_div <= '0;
            end

            if (!i_en || w_tick) begin
                r_ref <= '0;
            end else begin
                r_ref <= r_ref + RW'(1);
            end

            if (w_done_nx) begin
                r_frames <= (r_frames == FRM_LAST) ? '0 : r_frames + FW'(1);
            end

            // A trigger in the same cycle LOAD is entered stays pending for the next frame.
            r_pend <= w_trig | (r_pend & ~w_start);
        end
    end

    assign o_sclk  = r_sclk;
    assign o_sdat  = r_sdat;
    assign o_sload = r_sload;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_flash = r_flash;

endmodule
